// File: rtl/davos_stats_pkg.sv
// Shared register map, AXI response codes and FSM state types for the
// statistics register file.
package davos_stats_pkg;

    localparam logic [9:0]  REG_ID       = 10'h000;
    localparam logic [9:0]  REG_CTRL     = 10'h001;
    localparam logic [9:0]  REG_ERR      = 10'h002;
    localparam logic [9:0]  REG_CNT_BASE = 10'h040;

    localparam logic [1:0]  AXI_RESP_OK     = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

    localparam logic [31:0] BAD_DATA = 32'hdead_beef;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/stats_counter_mux.sv
// Read-data mux with the HI-word shadow register and the freeze snapshot of
// the counter bus; read data and response are registered when rd_en is high.
module stats_counter_mux
    import davos_stats_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned NUM_COUNTERS = 6,
    parameter int unsigned CNT_WIDTH    = 48,
    parameter logic [31:0] VERSION      = 32'h0001_0000
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_CHANNELS*NUM_COUNTERS*CNT_WIDTH-1:0] counters_in,
    input  logic                                          snap_en,
    input  logic                                          freeze,
    input  logic                                          rd_en,
    input  logic [9:0]                                    rd_word,
    input  logic [31:0]                                   err_val,
    output logic [31:0]                                   rdata,
    output logic [1:0]                                    rresp
);

    localparam int unsigned TOTAL = NUM_CHANNELS * NUM_COUNTERS;
    localparam int unsigned BUS   = TOTAL * CNT_WIDTH;

    logic [BUS-1:0]       snapshot;
    logic [BUS-1:0]       src;
    logic [31:0]          shadow;
    logic [9:0]           rel;
    logic [8:0]           k;
    logic                 is_cnt;
    logic [CNT_WIDTH-1:0] sel;
    logic [63:0]          sel64;
    logic [31:0]          next_data;
    logic [1:0]           next_resp;
    logic                 lo_hit;

    assign src    = freeze ? snapshot : counters_in;
    assign rel    = rd_word - REG_CNT_BASE;
    assign k      = rel[9:1];
    assign is_cnt = (rd_word >= REG_CNT_BASE) && (32'(k) < TOTAL);
    assign sel64  = 64'(sel);

    always_comb begin
        sel = '0;
        for (int unsigned j = 0; j < TOTAL; j++) begin
            if (32'(k) == j) sel = src[j*CNT_WIDTH +: CNT_WIDTH];
        end
    end

    always_comb begin
        next_data = BAD_DATA;
        next_resp = AXI_RESP_SLVERR;
        lo_hit    = 1'b0;
        if (rd_word == REG_ID) begin
            next_data = VERSION;
            next_resp = AXI_RESP_OK;
        end else if (rd_word == REG_CTRL) begin
            next_data = {30'd0, freeze, 1'b0};
            next_resp = AXI_RESP_OK;
        end else if (rd_word == REG_ERR) begin
            next_data = err_val;
            next_resp = AXI_RESP_OK;
        end else if (is_cnt) begin
            next_resp = AXI_RESP_OK;
            // HI word ignores k: it returns whatever the last LO read latched
            if (rel[0]) begin
                next_data = shadow;
            end else begin
                next_data = sel64[31:0];
                lo_hit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rresp    <= '0;
            shadow   <= '0;
            snapshot <= '0;
        end else begin
            if (snap_en) snapshot <= counters_in;
            if (rd_en) begin
                rdata <= next_data;
                rresp <= next_resp;
                if (lo_hit) shadow <= sel64[63:32];
            end
        end
    end

endmodule

// File: rtl/axil_stats_regfile.sv
// AXI-lite register file exposing free-running statistics counters with
// coherent 64-bit reads, a freeze snapshot, sticky error bits and a clear pulse.
module axil_stats_regfile
    import davos_stats_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned NUM_COUNTERS = 6,
    parameter int unsigned CNT_WIDTH    = 48,
    parameter logic [31:0] VERSION      = 32'h0001_0000
) (
    input  logic                                          mem_clk,
    input  logic                                          mem_reset,
    input  logic [31:0]                                   s_axil_awaddr,
    input  logic                                          s_axil_awvalid,
    output logic                                          s_axil_awready,
    input  logic [31:0]                                   s_axil_wdata,
    input  logic [3:0]                                    s_axil_wstrb,
    input  logic                                          s_axil_wvalid,
    output logic                                          s_axil_wready,
    output logic [1:0]                                    s_axil_bresp,
    output logic                                          s_axil_bvalid,
    input  logic                                          s_axil_bready,
    input  logic [31:0]                                   s_axil_araddr,
    input  logic                                          s_axil_arvalid,
    output logic                                          s_axil_arready,
    output logic [31:0]                                   s_axil_rdata,
    output logic [1:0]                                    s_axil_rresp,
    output logic                                          s_axil_rvalid,
    input  logic                                          s_axil_rready,
    input  logic [NUM_CHANNELS*NUM_COUNTERS*CNT_WIDTH-1:0] counters_in,
    input  logic [31:0]                                   error_in,
    output logic                                          clear_out
);

    wr_state_t   wstate, wstate_next;
    rd_state_t   rstate, rstate_next;
    logic [9:0]  wword, rword;
    logic        wr_fire, ar_fire;
    logic        wr_ctrl, wr_err, ctrl_en;
    logic [31:0] err, err_clr;
    logic        freeze, clear_q, snap_en;
    logic [1:0]  bresp_q, mux_rresp;
    logic [31:0] mux_rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                                s_axil_araddr[31:12], s_axil_araddr[1:0]};

    assign wword   = s_axil_awaddr[11:2];
    assign wr_fire = (wstate == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
    assign ar_fire = (rstate == R_IDLE) && s_axil_arvalid;
    assign wr_ctrl = wr_fire && (wword == REG_CTRL);
    assign wr_err  = wr_fire && (wword == REG_ERR);
    assign ctrl_en = wr_ctrl && s_axil_wstrb[0];
    assign snap_en = ctrl_en && s_axil_wdata[1] && !freeze;
    assign err_clr = wr_err ? (s_axil_wdata & {{8{s_axil_wstrb[3]}}, {8{s_axil_wstrb[2]}},
                                               {8{s_axil_wstrb[1]}}, {8{s_axil_wstrb[0]}}})
                            : '0;

    // Outputs are forced quiet combinationally so they read zero for the whole reset window
    assign s_axil_awready = !mem_reset && (wstate == W_IDLE);
    assign s_axil_wready  = !mem_reset && (wstate == W_IDLE);
    assign s_axil_bvalid  = !mem_reset && (wstate == W_RESP);
    assign s_axil_bresp   = mem_reset ? '0 : bresp_q;
    assign s_axil_arready = !mem_reset && (rstate == R_IDLE);
    assign s_axil_rvalid  = !mem_reset && (rstate == R_RESP);
    assign s_axil_rdata   = mem_reset ? '0 : mux_rdata;
    assign s_axil_rresp   = mem_reset ? '0 : mux_rresp;
    assign clear_out      = !mem_reset && clear_q;

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_next;
            rstate <= rstate_next;
        end
    end

    always_comb begin
        wstate_next = wstate;
        case (wstate)
            W_IDLE:  if (wr_fire) wstate_next = W_RESP;
            W_RESP:  if (s_axil_bready) wstate_next = W_IDLE;
            default: wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (ar_fire) rstate_next = R_DATA;
            R_DATA:  rstate_next = R_RESP;
            R_RESP:  if (s_axil_rready) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            err     <= '0;
            freeze  <= 1'b0;
            clear_q <= 1'b0;
            bresp_q <= '0;
            rword   <= '0;
        end else begin
            // set beats clear when both land on the same bit
            err     <= (err & ~err_clr) | error_in;
            clear_q <= ctrl_en && s_axil_wdata[0];
            if (ctrl_en) freeze <= s_axil_wdata[1];
            if (wr_fire) begin
                bresp_q <= (wword == REG_CTRL || wword == REG_ERR) ? AXI_RESP_OK : AXI_RESP_SLVERR;
            end
            if (ar_fire) rword <= s_axil_araddr[11:2];
        end
    end

    stats_counter_mux #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .NUM_COUNTERS (NUM_COUNTERS),
        .CNT_WIDTH    (CNT_WIDTH),
        .VERSION      (VERSION)
    ) u_mux (
        .clk         (mem_clk),
        .reset       (mem_reset),
        .counters_in (counters_in),
        .snap_en     (snap_en),
        .freeze      (freeze),
        .rd_en       (rstate == R_DATA),
        .rd_word     (rword),
        .err_val     (err),
        .rdata       (mux_rdata),
        .rresp       (mux_rresp)
    );

endmodule

// File: tb/tb_axil_stats_regfile.sv
// Directed bench for axil_stats_regfile with hand-computed expectations.
module tb_axil_stats_regfile;

    localparam int unsigned NC = 2;
    localparam int unsigned NK = 6;
    localparam int unsigned CW = 48;
    localparam logic [31:0] VER = 32'h0001_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       awaddr, wdata, araddr, rdata, error_in;
    logic [3:0]        wstrb;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready, clear_out;
    logic [1:0]        bresp, rresp;
    logic [NC*NK*CW-1:0] cnt_bus;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned rlat;
    logic        rstable, clr_a, clr_b, quiet;
    logic [31:0] d;
    logic [1:0]  r;

    always #5 clk = ~clk;

    axil_stats_regfile #(
        .NUM_CHANNELS (NC),
        .NUM_COUNTERS (NK),
        .CNT_WIDTH    (CW),
        .VERSION      (VER)
    ) dut (
        .mem_clk        (clk),
        .mem_reset      (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .counters_in    (cnt_bus),
        .error_in       (error_in),
        .clear_out      (clear_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input int unsigned k, input logic [CW-1:0] v);
        cnt_bus[k*CW +: CW] = v;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                             output logic [1:0] resp);
        int unsigned n;
        awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        clr_a = clear_out;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        resp = (n >= 20) ? 2'bxx : bresp;
        bready = 1'b1;
        tick();
        clr_b = clear_out;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int unsigned hold,
                            output logic [31:0] dat, output logic [1:0] resp);
        int unsigned n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        rlat = n;
        dat = rdata; resp = rresp;
        rstable = 1'b1;
        for (int unsigned h = 0; h < hold; h++) begin
            tick();
            if (!rvalid || rdata !== dat || rresp !== resp) rstable = 1'b0;
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; error_in = '0; cnt_bus = '0;
        clr_a = 1'b0; clr_b = 1'b0; rstable = 1'b0; rlat = 0;
        tick(); tick(); tick();
        check("rst_ready", {awready, wready, arready}, 3'b000);
        check("rst_valid", {bvalid, rvalid, clear_out}, 3'b000);
        check("rst_data", {bresp, rresp, rdata}, 36'h0);
        rst = 1'b0;
        tick();

        axi_read(32'h000, 0, d, r);
        check("id_data", d, VER);
        check("id_resp", r, 2'b00);
        check("id_latency", rlat, 1);

        set_cnt(3, 48'h1234_89AB_CDEF);
        axi_read(32'h118, 0, d, r);
        check("k3_lo", d, 32'h89AB_CDEF);
        check("k3_lo_resp", r, 2'b00);
        set_cnt(3, 48'h0);
        axi_read(32'h11C, 0, d, r);
        check("k3_hi", d, 32'h0000_1234);
        axi_read(32'h104, 0, d, r);
        check("hi_any_k", d, 32'h0000_1234);

        set_cnt(0, 48'hAAAA_1111_2222);
        axi_write(32'h004, 32'h2, 4'hF, r);
        check("freeze_bresp", r, 2'b00);
        for (int unsigned k = 0; k < NC*NK; k++) set_cnt(k, 48'h5555_3333_4444);
        axi_read(32'h100, 0, d, r);
        check("frozen_lo", d, 32'h1111_2222);
        axi_read(32'h104, 0, d, r);
        check("frozen_hi", d, 32'h0000_AAAA);
        axi_read(32'h004, 0, d, r);
        check("ctrl_rd", d, 32'h2);
        axi_write(32'h004, 32'h0, 4'hF, r);
        axi_read(32'h100, 0, d, r);
        check("live_lo", d, 32'h3333_4444);
        axi_write(32'h004, 32'h2, 4'h0, r);
        axi_read(32'h004, 0, d, r);
        check("ctrl_nostrb", d, 32'h0);

        error_in = 32'h4;
        tick();
        error_in = 32'h0;
        axi_read(32'h008, 0, d, r);
        check("err_sticky", d, 32'h4);
        error_in = 32'h4;
        axi_write(32'h008, 32'h4, 4'hF, r);
        error_in = 32'h0;
        check("err_bresp", r, 2'b00);
        axi_read(32'h008, 0, d, r);
        check("err_set_wins", d, 32'h4);
        axi_write(32'h008, 32'h4, 4'hF, r);
        axi_read(32'h008, 0, d, r);
        check("err_w1c", d, 32'h0);
        error_in = 32'h200;
        tick();
        error_in = 32'h0;
        axi_write(32'h008, 32'h200, 4'h1, r);
        axi_read(32'h008, 0, d, r);
        check("err_strb_off", d, 32'h200);
        axi_write(32'h008, 32'h200, 4'h2, r);
        axi_read(32'h008, 0, d, r);
        check("err_strb_on", d, 32'h0);

        axi_write(32'h004, 32'h1, 4'h1, r);
        check("clr_bresp", r, 2'b00);
        check("clr_pulse", {clr_a, clr_b}, 2'b10);
        axi_read(32'h004, 0, d, r);
        check("clr_reads0", d, 32'h0);
        axi_write(32'h100, 32'hFFFF_FFFF, 4'hF, r);
        check("wr_cnt_slverr", r, 2'b10);
        axi_write(32'h000, 32'h0, 4'hF, r);
        check("wr_id_slverr", r, 2'b10);
        axi_write(32'h0FC, 32'h0, 4'hF, r);
        check("wr_unmap_slverr", r, 2'b10);
        axi_read(32'h100, 0, d, r);
        check("cnt_unchanged", d, 32'h3333_4444);

        axi_read(32'h0FC, 5, d, r);
        check("unmap_rd", {r, d}, {2'b10, 32'hdead_beef});
        check("hold_stable", rstable, 1'b1);
        set_cnt(11, 48'h0007_CAFE_F00D);
        axi_read(32'h158, 0, d, r);
        check("last_k", {r, d}, {2'b00, 32'hCAFE_F00D});
        axi_read(32'h160, 3, d, r);
        check("past_k_lo", {r, d}, {2'b10, 32'hdead_beef});
        check("past_k_hold", rstable, 1'b1);
        axi_read(32'h164, 0, d, r);
        check("past_k_hi", {r, d}, {2'b10, 32'hdead_beef});

        araddr = 32'h000; arvalid = 1'b1;
        awaddr = 32'h004; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_outs", {rvalid, bvalid, arready, awready}, 4'b0000);
        tick();
        rst = 1'b0;
        bready = 1'b1; rready = 1'b1;
        quiet = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            if (rvalid || bvalid) quiet = 1'b0;
        end
        bready = 1'b0; rready = 1'b0;
        check("midrst_abandon", quiet, 1'b1);
        check("midrst_idle", {arready, awready}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
